// File: rtl/lsu_bus_ctrl_if.sv
// Data-bus interface between lsu_bus_ctrl (master) and the memory/bus
// fabric (slave). Single outstanding transaction with a req/ack handshake.
//   bus_req   : master -> slave, request held until ack or abort
//   bus_addr  : master -> slave, word-aligned byte address
//   bus_we    : master -> slave, byte enables (0000 for loads)
//   bus_wdata : master -> slave, write data
//   bus_ack   : slave -> master, one-cycle completion strobe
//   bus_rdata : slave -> master, read data valid with bus_ack
interface lsu_bus_ctrl_if;
  logic        bus_req;
  logic [31:0] bus_addr;
  logic [3:0]  bus_we;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  modport master (
    output bus_req, bus_addr, bus_we, bus_wdata,
    input  bus_ack, bus_rdata
  );

  modport slave (
    input  bus_req, bus_addr, bus_we, bus_wdata,
    output bus_ack, bus_rdata
  );
endinterface

// File: rtl/lsu_bus_ctrl.sv
// Memory-side stage downstream of the load/store unit. Accepts one
// word-aligned access at a time, runs it on the data bus (req/ack, variable
// latency), returns the raw bus word and stalls the pipeline until done.
// Misaligned requests are rejected without bus activity; an unanswered
// request is aborted after TIMEOUT_CYCLES with a bus_err pulse.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   mem_read/write    : load / store request (store wins if both set)
//   size, addr        : access size (00 b, 01 h, 1x w) and byte address
//   mem_we, mem_wdata : store byte enables and lane-replicated data
//   mem_rdata         : registered bus read word, valid in DONE
//   stall             : pipeline hold (combinational)
//   misaligned        : one-cycle pulse, access rejected
//   bus_err           : one-cycle pulse, timeout abort
//   bus               : data-bus master modport
module lsu_bus_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter int unsigned CNT_W          = 7
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic [1:0]            size,
  input  logic [31:0]           addr,
  input  logic [3:0]            mem_we,
  input  logic [31:0]           mem_wdata,
  output logic [31:0]           mem_rdata,
  output logic                  stall,
  output logic                  misaligned,
  output logic                  bus_err,
  lsu_bus_ctrl_if.master        bus
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_DONE
  } state_t;

  localparam logic [CNT_W-1:0] LP_CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t           r_state,   w_state_nxt;
  logic [CNT_W-1:0] r_cnt,     w_cnt_nxt;
  logic             r_req,     w_req_nxt;
  logic [31:0]      r_addr,    w_addr_nxt;
  logic [3:0]       r_we,      w_we_nxt;
  logic [31:0]      r_wdata,   w_wdata_nxt;
  logic [31:0]      r_rdata,   w_rdata_nxt;
  logic             r_is_load, w_is_load_nxt;
  logic             r_mis,     w_mis_nxt;
  logic             r_err,     w_err_nxt;

  logic w_req;
  logic w_mis_cond;

  assign w_req = mem_read | mem_write;

  always_comb begin
    w_mis_cond = 1'b0;
    case (size)
      2'b00:   w_mis_cond = 1'b0;
      2'b01:   w_mis_cond = addr[0];
      default: w_mis_cond = |addr[1:0];
    endcase
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_req_nxt     = r_req;
    w_addr_nxt    = r_addr;
    w_we_nxt      = r_we;
    w_wdata_nxt   = r_wdata;
    w_rdata_nxt   = r_rdata;
    w_is_load_nxt = r_is_load;
    w_mis_nxt     = 1'b0;
    w_err_nxt     = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (w_req) begin
          if (w_mis_cond) begin
            w_mis_nxt = 1'b1;
          end else begin
            w_addr_nxt    = {addr[31:2], 2'b00};
            w_we_nxt      = mem_write ? mem_we : 4'b0000;
            w_wdata_nxt   = mem_wdata;
            w_is_load_nxt = ~mem_write;
            w_req_nxt     = 1'b1;
            w_cnt_nxt     = '0;
            w_state_nxt   = ST_BUSY;
          end
        end
      end
      ST_BUSY: begin
        // ack is checked before the limit so a same-edge ack wins
        if (bus.bus_ack) begin
          w_req_nxt   = 1'b0;
          if (r_is_load) begin
            w_rdata_nxt = bus.bus_rdata;
          end
          w_state_nxt = ST_DONE;
        end else if (r_cnt == LP_CNT_LAST) begin
          w_req_nxt   = 1'b0;
          w_err_nxt   = 1'b1;
          w_rdata_nxt = '0;
          w_state_nxt = ST_DONE;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_req     <= 1'b0;
      r_addr    <= '0;
      r_we      <= '0;
      r_wdata   <= '0;
      r_rdata   <= '0;
      r_is_load <= 1'b0;
      r_mis     <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_req     <= w_req_nxt;
      r_addr    <= w_addr_nxt;
      r_we      <= w_we_nxt;
      r_wdata   <= w_wdata_nxt;
      r_rdata   <= w_rdata_nxt;
      r_is_load <= w_is_load_nxt;
      r_mis     <= w_mis_nxt;
      r_err     <= w_err_nxt;
    end
  end

  // A misaligned request in IDLE is rejected immediately, so it never stalls.
  assign stall = w_req & (r_state != ST_DONE) & ~((r_state == ST_IDLE) & w_mis_cond);

  assign mem_rdata     = r_rdata;
  assign misaligned    = r_mis;
  assign bus_err       = r_err;
  assign bus.bus_req   = r_req;
  assign bus.bus_addr  = r_addr;
  assign bus.bus_we    = r_we;
  assign bus.bus_wdata = r_wdata;

endmodule

// File: tb/tb_lsu_bus_ctrl.sv
// Self-checking bench for lsu_bus_ctrl: directed cases followed by random
// transactions, checked against a transaction-level reference model.
module tb_lsu_bus_ctrl;

  localparam int unsigned TMO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_read, mem_write;
  logic [1:0]  size;
  logic [31:0] addr;
  logic [3:0]  mem_we;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        stall, misaligned, bus_err;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state: last word the LSU should see on mem_rdata
  logic [31:0] m_rdata;

  lsu_bus_ctrl_if u_if ();

  lsu_bus_ctrl #(
    .TIMEOUT_CYCLES (TMO),
    .CNT_W          (7)
  ) u_dut (
    .clk        (clk),
    .rst        (rst),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .size       (size),
    .addr       (addr),
    .mem_we     (mem_we),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .stall      (stall),
    .misaligned (misaligned),
    .bus_err    (bus_err),
    .bus        (u_if.master)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic model_mis(input logic [1:0] sz, input logic [31:0] a);
    if (sz == 2'b00) return 1'b0;
    if (sz == 2'b01) return a[0];
    return a[1:0] != 2'b00;
  endfunction

  task automatic drop_inputs();
    mem_read  = 1'b0;
    mem_write = 1'b0;
  endtask

  // Entered and left just after a rising edge. lat = BUSY cycle index on
  // which the bus acks; negative means the bus never answers.
  task automatic run_txn(input logic rd, input logic wr, input logic [1:0] sz,
                         input logic [31:0] a, input logic [3:0] be,
                         input logic [31:0] wd, input int lat,
                         input logic [31:0] rdat, input logic spur_ack);
    logic        is_store, timeout;
    logic [3:0]  exp_we;
    int          exp_stall, exp_req;
    int          stall_cnt, req_cnt, cyc;
    bit          done;
    mem_read  = rd;
    mem_write = wr;
    size      = sz;
    addr      = a;
    mem_we    = be;
    mem_wdata = wd;

    if (!(rd | wr)) begin
      @(negedge clk);
      check_eq("idle_stall", stall, 0);
      check_eq("idle_req", u_if.bus_req, 0);
      @(posedge clk); #1;
      return;
    end

    if (model_mis(sz, a)) begin
      @(negedge clk);
      check_eq("mis_stall", stall, 0);
      check_eq("mis_req0", u_if.bus_req, 0);
      @(posedge clk); #1;
      drop_inputs();
      @(negedge clk);
      check_eq("mis_pulse", misaligned, 1);
      check_eq("mis_req1", u_if.bus_req, 0);
      check_eq("mis_rdata", mem_rdata, m_rdata);
      @(posedge clk); #1;
      @(negedge clk);
      check_eq("mis_pulse_end", misaligned, 0);
      check_eq("mis_req2", u_if.bus_req, 0);
      @(posedge clk); #1;
      return;
    end

    is_store  = wr;
    exp_we    = is_store ? be : 4'b0000;
    timeout   = (lat < 0) || (lat >= int'(TMO));
    exp_req   = timeout ? int'(TMO) : lat + 1;
    exp_stall = exp_req + 1;
    if (timeout)        m_rdata = 32'h0;
    else if (!is_store) m_rdata = rdat;

    stall_cnt = 0; req_cnt = 0; cyc = 0; done = 0;
    while (!done && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (stall) begin
        stall_cnt++;
        check_eq("busy_err", bus_err, 0);
        if (u_if.bus_req) begin
          check_eq("bus_addr", u_if.bus_addr, {a[31:2], 2'b00});
          check_eq("bus_we", u_if.bus_we, exp_we);
          check_eq("bus_wdata", u_if.bus_wdata, wd);
          if (lat >= 0 && req_cnt == lat) begin
            u_if.bus_ack   = 1'b1;
            u_if.bus_rdata = rdat;
          end
          req_cnt++;
        end
      end else begin
        done = 1;
        check_eq("stall_cycles", stall_cnt, exp_stall);
        check_eq("req_cycles", req_cnt, exp_req);
        check_eq("done_req", u_if.bus_req, 0);
        check_eq("done_err", bus_err, timeout);
        check_eq("done_mis", misaligned, 0);
        check_eq("mem_rdata", mem_rdata, m_rdata);
        // an ack arriving in DONE must be ignored
        if (spur_ack) begin
          u_if.bus_ack   = 1'b1;
          u_if.bus_rdata = $urandom;
        end
      end
      @(posedge clk); #1;
      u_if.bus_ack   = 1'b0;
      u_if.bus_rdata = $urandom;
    end
    if (!done) check_eq("txn_wait_expired", 1, 0);
    drop_inputs();
  endtask

  task automatic idle_check(input string tag);
    @(negedge clk);
    check_eq({tag, "_stall"}, stall, 0);
    check_eq({tag, "_req"}, u_if.bus_req, 0);
    check_eq({tag, "_err"}, bus_err, 0);
    check_eq({tag, "_mis"}, misaligned, 0);
    @(posedge clk); #1;
  endtask

  initial begin
    logic        rd, wr;
    logic [1:0]  sz;
    logic [31:0] a;
    int          lat;

    rst = 1'b1;
    drop_inputs();
    size = 2'b10; addr = '0; mem_we = '0; mem_wdata = '0;
    u_if.bus_ack = 1'b0; u_if.bus_rdata = '0;
    m_rdata = 32'h0;
    @(posedge clk); #1;
    @(negedge clk);
    check_eq("rst_req", u_if.bus_req, 0);
    check_eq("rst_addr", u_if.bus_addr, 0);
    check_eq("rst_we", u_if.bus_we, 0);
    check_eq("rst_wdata", u_if.bus_wdata, 0);
    check_eq("rst_rdata", mem_rdata, 0);
    check_eq("rst_mis", misaligned, 0);
    check_eq("rst_err", bus_err, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    idle_check("post_rst");

    // load word, zero wait
    run_txn(1, 0, 2'b10, 32'h1004, 4'hF, 32'h1111_2222, 0, 32'hCAFEBABE, 0);
    // store byte, 5 BUSY cycles
    run_txn(0, 1, 2'b00, 32'h2003, 4'b1000, 32'h5A5A5A5A, 4, 32'h0, 0);
    // misaligned half
    run_txn(1, 0, 2'b01, 32'h3001, 4'h0, 32'h0, 0, 32'h0, 0);
    // timeout, never ack
    run_txn(1, 0, 2'b10, 32'h4000, 4'h0, 32'h0, -1, 32'h0, 0);
    idle_check("post_tmo");
    // ack on the last allowed cycle wins over timeout
    run_txn(1, 0, 2'b10, 32'h4004, 4'h0, 32'h0, TMO - 1, 32'h1234_5678, 0);
    // back-to-back load then store
    run_txn(1, 0, 2'b10, 32'h10, 4'h0, 32'h0, 1, 32'hA5A5_0F0F, 0);
    run_txn(0, 1, 2'b10, 32'h14, 4'b1111, 32'hDEAD_BEEF, 0, 32'h0, 1);
    // both set acts as store; mem_rdata unchanged
    run_txn(1, 1, 2'b01, 32'h22, 4'b1100, 32'h7777_8888, 2, 32'hFFFF_FFFF, 0);

    // reset during BUSY
    mem_read = 1'b1; size = 2'b10; addr = 32'h40;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    drop_inputs();
    @(posedge clk); #1;
    @(negedge clk);
    check_eq("midrst_req", u_if.bus_req, 0);
    check_eq("midrst_stall", stall, 0);
    check_eq("midrst_err", bus_err, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    m_rdata = 32'h0;
    u_if.bus_ack = 1'b1; u_if.bus_rdata = 32'hBAD0_BAD0;
    @(posedge clk); #1;
    u_if.bus_ack = 1'b0;
    @(negedge clk);
    check_eq("late_ack_req", u_if.bus_req, 0);
    check_eq("late_ack_err", bus_err, 0);
    check_eq("late_ack_rdata", mem_rdata, m_rdata);
    check_eq("late_ack_stall", stall, 0);
    @(posedge clk); #1;
    // counter must restart cleanly after reset
    run_txn(1, 0, 2'b10, 32'h80, 4'h0, 32'h0, -1, 32'h0, 0);

    for (int i = 0; i < 250; i++) begin
      rd  = $urandom_range(0, 1);
      wr  = $urandom_range(0, 1);
      if ($urandom_range(0, 7) == 0) begin rd = 0; wr = 0; end
      sz  = 2'($urandom_range(0, 3));
      a   = $urandom;
      if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
      lat = int'($urandom_range(0, 6)) - 1;
      run_txn(rd, wr, sz, a, 4'($urandom), $urandom, lat, $urandom, 1'($urandom));
    end
    idle_check("final");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lsu_bus_ctrl.md
Name: lsu_bus_ctrl

Overview:
Memory-side stage directly downstream of the load/store unit.
- Takes the LSU's word-aligned access request (byte-enable mask, replicated write data, raw address) and runs it on a single-outstanding, variable-latency data bus using a req/ack handshake.
- Returns the raw 32-bit bus word to the LSU for byte/half extraction.
- Stalls the pipeline until the access completes.
- Flags misaligned accesses and bus timeouts.

Parameters:
TIMEOUT_CYCLES, 64, max cycles in BUSY waiting for bus_ack before aborting with error; must be >= 2
CNT_W, 7, width of timeout counter; must hold TIMEOUT_CYCLES

Ports:
clk  input  1  system clock; all state updates on rising edge
rst  input  1  synchronous active-high reset
mem_read  input  1  load request from pipeline; held stable while stall=1
mem_write  input  1  store request from pipeline; held stable while stall=1
size  input  2  access size: 00 byte, 01 half, 10 word; 11 treated as word
addr  input  32  byte address of access
mem_we  input  4  store byte-enable mask from LSU
mem_wdata  input  32  store data from LSU, already lane-replicated
mem_rdata  output  32  registered bus read word, valid in DONE
stall  output  1  pipeline hold request
misaligned  output  1  one-cycle pulse; access rejected, no bus activity
bus_err  output  1  one-cycle pulse; timeout abort
bus_req  output  1  bus request, registered
bus_addr  output  32  {addr[31:2],2'b00}, registered
bus_we  output  4  byte enables, registered; 0000 for loads
bus_wdata  output  32  registered write data
bus_ack  input  1  bus completion strobe, one cycle
bus_rdata  input  32  read data, valid when bus_ack=1

Behaviour:
- Reset (rst=1 at an edge):
  - state=IDLE; timeout counter=0.
  - bus_req, bus_we, bus_addr, bus_wdata, mem_rdata all 0.
  - misaligned=0, bus_err=0.
  - Applies mid-transaction: bus_req drops the next cycle; a late bus_ack after reset is ignored; no error is raised.
- Request definition: req = mem_read | mem_write. If both are set, treat as a store.
- Alignment check (combinational on inputs):
  - half with addr[0]=1 is misaligned.
  - word with addr[1:0]!=00 is misaligned.
  - byte is never misaligned.
- stall = req & (state!=DONE) & ~(state==IDLE & misaligned_cond). Combinational.
- FSM, IDLE:
  - If req and misaligned_cond: pulse misaligned next cycle, stall=0 this cycle, stay IDLE, no bus_req.
  - Else if req: latch bus_addr, bus_we (mem_write ? mem_we : 0000), bus_wdata; set bus_req=1; counter=0; go to BUSY.
- FSM, BUSY:
  - bus_req held at 1; bus_addr, bus_we and bus_wdata are frozen.
  - On bus_ack: bus_req=0; mem_rdata<=bus_rdata (for loads only; stores leave mem_rdata unchanged); go to DONE.
  - Else, if counter==TIMEOUT_CYCLES-1: bus_req=0, pulse bus_err, go to DONE with mem_rdata=32'h0.
  - Else counter++.
- FSM, DONE (exactly 1 cycle): stall=0 so the pipeline advances; go to IDLE unconditionally.
- Latency: with bus_ack in the first BUSY cycle, stall is high for 2 cycles (IDLE, BUSY). The request completes at the third edge.
- Back-to-back requests: the next request is seen in IDLE one cycle after DONE. There is no overlap; at most one transaction is outstanding.
- bus_ack seen in IDLE or DONE is ignored.
- bus_ack on the same edge as the timeout limit: the ack wins and no bus_err is raised.
- Inputs changing while stall=1 is a protocol violation. The latched bus fields protect the bus side.

Test Plan:
- Reset: hold rst 2 cycles during BUSY -> bus_req=0, state IDLE, stall=0 with no req, bus_err never pulses, later bus_ack ignored.
- Load word, zero-wait: mem_read=1, size=10, addr=0x1004, bus_ack in first BUSY cycle with bus_rdata=0xCAFEBABE -> bus_addr=0x1004, bus_we=0000, stall high 2 cycles, mem_rdata=0xCAFEBABE in DONE.
- Store byte, 5 wait states: mem_write=1, size=00, addr=0x2003, mem_we=1000, mem_wdata=0x5A5A5A5A -> bus_addr=0x2000, bus_we=1000, bus_wdata=0x5A5A5A5A, all stable through 5 BUSY cycles, stall high 6 cycles.
- Misaligned: mem_read=1, size=01, addr=0x3001 -> misaligned pulse, bus_req stays 0, stall=0 in that cycle.
- Timeout: TIMEOUT_CYCLES=4, never ack -> bus_req high exactly 4 cycles, bus_err pulse, mem_rdata=0, then DONE and IDLE. Repeat with ack on the 4th cycle -> no bus_err.
- Back-to-back: load 0x10 then store 0x14 with no gap -> two separate req pulses, no overlap, bus_we=0000 then the store mask.
